// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, EX-stage jump/branch redirects and
// jump-via-memory (JM) indirection, with a saturating count of taken redirects.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter int              PC_INC   = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        pc_sel,
  input  logic              br_z,
  input  logic              br_n,
  input  logic              z,
  input  logic              n,
  input  logic [PC_W-1:0]   rs_val,
  input  logic [PC_W-1:0]   jm_rdata,
  input  logic              jm_rvalid,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus,
  output logic              fetch_valid,
  output logic              flush,
  output logic              jm_req,
  output logic [PC_W-1:0]   jm_addr,
  output logic [CNT_W-1:0]  redirect_count
);

  typedef enum logic {RUN, JM_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               jm_req_q, jm_req_d;
  logic [PC_W-1:0]    jm_addr_q, jm_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accepted;
  logic br_taken;
  logic take_j;
  logic take_jm;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    accepted = (state_q == RUN) && redirect_valid && !stall;
    // Both enables clear means an unconditional jump.
    br_taken = (!br_z && !br_n) || (br_z && z) || (br_n && n);
    take_j   = accepted && (pc_sel == 2'b01) && br_taken;
    take_jm  = accepted && (pc_sel == 2'b10);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    jm_req_d  = jm_req_q;
    jm_addr_d = jm_addr_q;
    cnt_d     = cnt_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (take_j) begin
            pc_d  = rs_val;
            cnt_d = sat_inc(cnt_q);
          end else if (take_jm) begin
            state_d   = JM_WAIT;
            jm_req_d  = 1'b1;
            jm_addr_d = rs_val;
          end else begin
            pc_d = pc_plus;
          end
        end
      end
      JM_WAIT: begin
        // Waits indefinitely for the pointer read; only reset can abort it.
        if (jm_rvalid) begin
          pc_d     = jm_rdata;
          jm_req_d = 1'b0;
          state_d  = RUN;
          cnt_d    = sat_inc(cnt_q);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      jm_req_q  <= 1'b0;
      jm_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      jm_req_q  <= jm_req_d;
      jm_addr_q <= jm_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign pc_plus        = pc_q + PC_W'(PC_INC);
  assign fetch_valid    = (state_q == RUN);
  assign flush          = take_j || take_jm;
  assign jm_req         = jm_req_q;
  assign jm_addr        = jm_addr_q;
  assign redirect_count = cnt_q;

endmodule
